keypad_scanner: RTL

// Input-side counterpart of the multiplexed 7-seg display driver: it drives a 4x4 matrix

---
 rtl/keypad_scanner.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad column scanner with debounced hex key output
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DLAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_SCANS);
  // Nibble (r*4+c) holds the hex code printed on the key at row r, column c
  localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

  typedef enum logic [1:0] {IDLE, CAND, PRESSED, RELEASE} state_t;

  logic [3:0]    row_s1, row_s2;
  logic [DW-1:0] div;
  logic [1:0]    col_idx;
  logic [3:0]    samp [4];
  logic          tick, scan_end;
  logic [4:0]    n_keys;
  logic [3:0]    code;
  logic          none, single, mul;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]    cand, cand_n, key_n;
  logic          valid_n, multi_n;

  assign tick     = (div == DLAST);
  assign scan_end = tick && (col_idx == 2'd3);
  assign col      = ~(4'b0001 << col_idx);
  assign key_held = (state == PRESSED) || (state == RELEASE);
  assign none     = (n_keys == 5'd0);
  assign single   = (n_keys == 5'd1);
  assign mul      = (n_keys > 5'd1);
  assign cnt_inc  = (cnt == CMAX) ? cnt : cnt + 1'b1;

  // Row synchronizer, dwell counter, per-column row sampling and column advance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_s1  <= 4'hF;
      row_s2  <= 4'hF;
      div     <= '0;
      col_idx <= '0;
      for (int i = 0; i < 4; i++) samp[i] <= 4'hF;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
      div    <= tick ? '0 : div + 1'b1;
      if (tick) begin
        samp[col_idx] <= row_s2;
        col_idx       <= col_idx + 2'd1;
      end
    end
  end

  // Classify the full scan; column 3 is taken live since its sample lands on this edge
  always_comb begin
    n_keys = '0;
    code   = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!((c == 3) ? row_s2[r] : samp[c][r])) begin
          n_keys = n_keys + 5'd1;
          code   = KEY_MAP[(r * 4 + c) * 4 +: 4];
        end
  end

  // Debounce state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      key       <= '0;
      key_valid <= 1'b0;
      multi     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cand      <= cand_n;
      key       <= key_n;
      key_valid <= valid_n;
      multi     <= multi_n;
    end
  end

  // Debounce next-state: only acts on scan end; a new key needs a full release first
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    key_n   = key;
    valid_n = 1'b0;
    multi_n = multi;
    if (scan_end) begin
      multi_n = mul;
      case (state)
        IDLE: if (single) begin
          cand_n  = code;
          cnt_n   = CW'(1);
          state_n = (DEBOUNCE_SCANS == 1) ? PRESSED : CAND;
          key_n   = (DEBOUNCE_SCANS == 1) ? code : key;
          valid_n = (DEBOUNCE_SCANS == 1);
        end
        CAND: if (single && code == cand) begin
          cnt_n = cnt_inc;
          if (cnt_inc == CMAX) begin
            state_n = PRESSED;
            key_n   = cand;
            valid_n = 1'b1;
          end
        end else if (single) begin
          cand_n = code;
          cnt_n  = CW'(1);
        end else begin
          state_n = IDLE;
          cnt_n   = '0;
        end
        PRESSED: if (none) begin
          cnt_n   = (DEBOUNCE_SCANS == 1) ? '0 : CW'(1);
          state_n = (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE;
        end
        RELEASE: if (none) begin
          cnt_n   = (cnt_inc == CMAX) ? '0 : cnt_inc;
          state_n = (cnt_inc == CMAX) ? IDLE : RELEASE;
        end else begin
          state_n = PRESSED;
          cnt_n   = CMAX;
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule
